// File: rtl/mmio_uart_responder.sv
// MMIO target bridging a 4-register bus window to TX/RX byte FIFOs.
// Optional internal TX->RX loopback when MMIO_LOOPBACK_EN is defined.
`timescale 1ns/1ps
module mmio_uart_responder #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8,
  parameter int BASE   = 28,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [AWIDTH-1:0] addr,
  input  logic              rd,
  input  logic              wr,
  inout  wire  [DWIDTH-1:0] data,
  output logic              hit,
  output logic [DWIDTH-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [DWIDTH-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int BASE_W = BASE >> 2;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [1:0]        offset;
  logic              rd_rxd, rxrd_q, rxrd_d;
  logic              rx_trail, flush, clr_sticky;
  logic              tx_push_req, tx_push, tx_pop, rx_push, rx_pop;
  logic              tx_empty, tx_full, rx_empty, rx_full;
  logic              tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;
  logic [PW-1:0]     tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
  logic [PW-1:0]     rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
  logic [CW-1:0]     tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [DWIDTH-1:0] tx_mem_q [DEPTH];
  logic [DWIDTH-1:0] tx_mem_d [DEPTH];
  logic [DWIDTH-1:0] rx_mem_q [DEPTH];
  logic [DWIDTH-1:0] rx_mem_d [DEPTH];
  logic [DWIDTH-1:0] rx_in, rd_val, stat;

  assign offset   = addr[1:0];
  assign hit      = (addr[AWIDTH-1:2] == BASE_W[AWIDTH-3:0]);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == FULL_CNT);
  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == FULL_CNT);
  assign tx_data  = tx_mem_q[tx_rptr_q];

  assign rd_rxd      = rd && hit && (offset == 2'd1);
  assign rxrd_d      = rd_rxd;
  // The RX pop lands on the trailing edge so the head is stable across a long read.
  assign rx_trail    = rxrd_q && !rd_rxd;
  assign rx_pop      = rx_trail && !rx_empty;
  assign tx_push_req = wr && hit && (offset == 2'd0);
  assign flush       = wr && hit && (offset == 2'd3) && data[1];
  assign clr_sticky  = wr && hit && (offset == 2'd3) && data[0];

`ifdef MMIO_LOOPBACK_EN
  logic unused_ext;
  assign unused_ext = ^{tx_ready, rx_valid, rx_data};
  assign tx_pop   = !tx_empty && !rx_full;
  assign rx_push  = tx_pop;
  assign rx_in    = tx_data;
  assign tx_valid = 1'b0;
  assign rx_ready = 1'b0;
`else
  assign tx_pop   = !tx_empty && tx_ready;
  assign rx_push  = rx_valid && !rx_full;
  assign rx_in    = rx_data;
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
`endif

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  assign tx_push = tx_push_req && (!tx_full || tx_pop);

  always_comb begin
    stat      = '0;
    stat[5:0] = {rx_unf_q, tx_ovf_q, rx_empty, rx_full, tx_empty, tx_full};
    rd_val    = '0;
    case (offset)
      2'd1:    rd_val = rx_empty ? '0 : rx_mem_q[rx_rptr_q];
      2'd2:    rd_val = stat;
      default: rd_val = '0;
    endcase
  end

  assign data = (rd && hit) ? rd_val : {DWIDTH{1'bz}};

  always_comb begin
    tx_mem_d  = tx_mem_q;
    rx_mem_d  = rx_mem_q;
    tx_wptr_d = tx_wptr_q;
    tx_rptr_d = tx_rptr_q;
    rx_wptr_d = rx_wptr_q;
    rx_rptr_d = rx_rptr_q;
    tx_cnt_d  = tx_cnt_q;
    rx_cnt_d  = rx_cnt_q;
    tx_ovf_d  = tx_ovf_q;
    rx_unf_d  = rx_unf_q;
    if (clr_sticky) begin
      tx_ovf_d = 1'b0;
      rx_unf_d = 1'b0;
    end
    if (tx_push_req && !tx_push) tx_ovf_d = 1'b1;
    if (rx_trail && rx_empty)    rx_unf_d = 1'b1;
    if (flush) begin
      tx_wptr_d = '0;
      tx_rptr_d = '0;
      rx_wptr_d = '0;
      rx_rptr_d = '0;
      tx_cnt_d  = '0;
      rx_cnt_d  = '0;
    end else begin
      if (tx_push) begin
        tx_mem_d[tx_wptr_q] = data;
        tx_wptr_d = tx_wptr_q + PW'(1);
      end
      if (tx_pop) tx_rptr_d = tx_rptr_q + PW'(1);
      if (rx_push) begin
        rx_mem_d[rx_wptr_q] = rx_in;
        rx_wptr_d = rx_wptr_q + PW'(1);
      end
      if (rx_pop) rx_rptr_d = rx_rptr_q + PW'(1);
      tx_cnt_d = tx_cnt_q + CW'(tx_push) - CW'(tx_pop);
      rx_cnt_d = rx_cnt_q + CW'(rx_push) - CW'(rx_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxrd_q    <= 1'b0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      rx_cnt_q  <= '0;
      tx_ovf_q  <= 1'b0;
      rx_unf_q  <= 1'b0;
    end else begin
      rxrd_q    <= rxrd_d;
      tx_wptr_q <= tx_wptr_d;
      tx_rptr_q <= tx_rptr_d;
      rx_wptr_q <= rx_wptr_d;
      rx_rptr_q <= rx_rptr_d;
      tx_cnt_q  <= tx_cnt_d;
      rx_cnt_q  <= rx_cnt_d;
      tx_ovf_q  <= tx_ovf_d;
      rx_unf_q  <= rx_unf_d;
    end
  end

  // Storage needs no reset; occupancy is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    tx_mem_q <= tx_mem_d;
    rx_mem_q <= rx_mem_d;
  end

endmodule

// File: tb/tb_mmio_uart_responder.sv
// Directed bench for mmio_uart_responder (window at 28..31, DEPTH 4).
`timescale 1ns/1ps
module tb_mmio_uart_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] addr = '0;
  logic       rd = 1'b0, wr = 1'b0;
  logic       drv_en = 1'b0;
  logic [7:0] drv_val = '0;
  wire  [7:0] data;
  logic       hit;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       rx_ready;
  int checks = 0;
  int errors = 0;

  assign data = drv_en ? drv_val : 8'bz;

  always #5 clk = ~clk;

  mmio_uart_responder #(.AWIDTH(5), .DWIDTH(8), .BASE(28), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .rd(rd), .wr(wr), .data(data),
    .hit(hit), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_bus(input logic [4:0] a, input logic [7:0] v);
    addr = a; drv_val = v; drv_en = 1'b1; wr = 1'b1;
    tick();
    wr = 1'b0; drv_en = 1'b0;
  endtask

  // Holds rd for n cycles checking data each cycle, then lets the trailing edge clock in.
  task automatic rd_bus(input logic [4:0] a, input int n, input logic [7:0] exp, input string tag);
    addr = a; rd = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      chk(tag, data, exp);
      @(posedge clk);
      #1;
    end
    rd = 1'b0;
    tick();
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
    rst = 1'b1;
    tick();
    chk("idle_hit", {7'b0, hit}, 8'h00);
    rd_bus(5'd30, 1, 8'h0A, "stat_after_reset");

`ifdef MMIO_LOOPBACK_EN
    wr_bus(5'd28, 8'h3C);
    tick();
    rd_bus(5'd30, 1, 8'h02, "lb_stat");
    chk("lb_tx_valid", {7'b0, tx_valid}, 8'h00);
    chk("lb_rx_ready", {7'b0, rx_ready}, 8'h00);
    rd_bus(5'd29, 2, 8'h3C, "lb_rxd");
    rd_bus(5'd30, 1, 8'h0A, "lb_stat_empty");
`else
    wr_bus(5'd28, 8'h5A);
    chk("tx_valid_one", {7'b0, tx_valid}, 8'h01);
    chk("tx_data_one", tx_data, 8'h5A);
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("tx_valid_drained", {7'b0, tx_valid}, 8'h00);

    for (int i = 1; i <= 5; i++) wr_bus(5'd28, 8'(i));
    rd_bus(5'd30, 1, 8'h19, "stat_tx_ovf");
    tx_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("tx_drain", tx_data, 8'(i));
      tick();
    end
    tx_ready = 1'b0;
    chk("tx_valid_after_drain", {7'b0, tx_valid}, 8'h00);
    rd_bus(5'd30, 1, 8'h1A, "stat_ovf_sticky");
    wr_bus(5'd31, 8'h01);
    rd_bus(5'd30, 1, 8'h0A, "stat_ovf_cleared");

    rx_valid = 1'b1; rx_data = 8'hA1;
    tick();
    rx_data = 8'hA2;
    tick();
    rx_valid = 1'b0;
    rd_bus(5'd30, 1, 8'h02, "stat_rx_nonempty");
    rd_bus(5'd29, 3, 8'hA1, "rxd_long_read");
    rd_bus(5'd29, 1, 8'hA2, "rxd_second");
    rd_bus(5'd29, 1, 8'h00, "rxd_empty");
    rd_bus(5'd30, 1, 8'h2A, "stat_rx_unf");
    wr_bus(5'd31, 8'h01);

    rx_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rx_data = 8'hB0 + 8'(i);
      tick();
    end
    chk("rx_ready_full", {7'b0, rx_ready}, 8'h00);
    rx_data = 8'hCC;
    rd_bus(5'd29, 1, 8'hB0, "rxd_full_read");
    chk("rx_ready_after_pop", {7'b0, rx_ready}, 8'h01);
    rx_valid = 1'b0;
    rd_bus(5'd29, 1, 8'hB1, "rxd_b1");
    rd_bus(5'd29, 1, 8'hB2, "rxd_b2");
    rd_bus(5'd29, 1, 8'hB3, "rxd_b3");
    rd_bus(5'd30, 1, 8'h0A, "stat_rx_no_extra_push");

    for (int i = 0; i < 4; i++) wr_bus(5'd28, 8'h11 + 8'(i));
    tx_ready = 1'b1;
    wr_bus(5'd28, 8'h19);
    tx_ready = 1'b0;
    rd_bus(5'd30, 1, 8'h09, "stat_full_push_pop");
    chk("tx_head_after_push_pop", tx_data, 8'h12);
    wr_bus(5'd31, 8'h02);
    rd_bus(5'd30, 1, 8'h0A, "stat_after_flush");
    chk("tx_valid_after_flush", {7'b0, tx_valid}, 8'h00);

    addr = 5'd3; rd = 1'b1;
    #1;
    chk("out_of_window_hit", {7'b0, hit}, 8'h00);
    rd = 1'b0;
    wr_bus(5'd0, 8'h55);
    rd_bus(5'd30, 1, 8'h0A, "stat_out_of_window_write");

    rx_valid = 1'b1; rx_data = 8'h77;
    tick();
    rx_valid = 1'b0;
    addr = 5'd29; rd = 1'b1;
    tick();
    rst = 1'b0;
    #2;
    rd = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rd_bus(5'd30, 1, 8'h0A, "stat_reset_mid_read");
    chk("rx_ready_reset_mid_read", {7'b0, rx_ready}, 8'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
